// File: rtl/ram_loader.sv
// ram_loader: receives a length-prefixed, XOR-checksummed byte stream and writes it
// into RAM as 32-bit little-endian words starting at base_addr.
module ram_loader #(
    parameter int num_kbytes = 128,
    parameter int base_addr  = 0,
    localparam int aw = $clog2(num_kbytes * 1024)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          in_valid_i,
    input  logic [7:0]    in_data_i,
    output logic          in_ready_o,
    output logic          ram_en_o,
    output logic          ram_wr_o,
    output logic          ram_be_o,
    output logic [aw-1:0] ram_addr_o,
    output logic [31:0]   ram_wdata_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR} state_t;
    localparam logic [31:0] limit = 32'(num_kbytes * 1024 - base_addr);
    state_t        state_q, state_d;
    logic [31:0]   len_q, len_d, cnt_q, cnt_d, word_q, word_d, n_full;
    logic [aw-1:0] addr_q, addr_d, ram_addr_q;
    logic [7:0]    csum_q, csum_d;
    logic [31:0]   ram_wdata_q;
    logic          in_ready_q, wr_q, busy_q, done_q, err_q, acc;
    assign acc    = in_valid_i && in_ready_q;
    assign n_full = {in_data_i, len_q[31:8]};
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        addr_d  = addr_q;
        csum_d  = csum_q;
        case (state_q)
            IDLE, DONE, ERR: if (start_i) begin
                state_d = LEN;
                len_d   = '0;
                cnt_d   = '0;
                word_d  = '0;
                addr_d  = aw'(base_addr);
                csum_d  = '0;
            end
            LEN: if (acc) begin
                len_d = n_full;
                cnt_d = cnt_q == 32'd3 ? '0 : cnt_q + 32'd1;
                if (cnt_q == 32'd3)
                    state_d = n_full > limit ? ERR : n_full == '0 ? CSUM : DATA;
            end
            DATA: if (acc) begin
                word_d  = word_q | (32'(in_data_i) << {cnt_q[1:0], 3'b000});
                csum_d  = csum_q ^ in_data_i;
                cnt_d   = cnt_q + 32'd1;
                state_d = (cnt_q[1:0] == 2'd3 || cnt_q == len_q - 32'd1) ? WRITE : DATA;
            end
            WRITE: begin
                addr_d  = addr_q + aw'(4);
                word_d  = '0;
                state_d = cnt_q == len_q ? CSUM : DATA;
            end
            CSUM: if (acc) state_d = in_data_i == csum_q ? DONE : ERR;
            default: state_d = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            csum_q      <= '0;
            in_ready_q  <= 1'b0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            csum_q      <= csum_d;
            in_ready_q  <= state_d inside {LEN, DATA, CSUM};
            wr_q        <= state_d == WRITE;
            busy_q      <= state_d inside {LEN, DATA, WRITE, CSUM};
            done_q      <= state_d == DONE;
            err_q       <= state_d == ERR;
            ram_addr_q  <= state_d == WRITE ? addr_d : '0;
            ram_wdata_q <= state_d == WRITE ? word_d : '0;
        end
    end
    // A reset landing on a WRITE cycle must suppress that write immediately.
    assign ram_en_o    = wr_q & ~rst;
    assign ram_wr_o    = wr_q & ~rst;
    assign ram_be_o    = 1'b0;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign in_ready_o  = in_ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed checks of ram_loader with default geometry (u0) and a
// 1 kB RAM with base 0x3F8 (u1) for the capacity boundary.
module tb_ram_loader;
    logic clk = 1'b0, rst, start, valid, sel, gaps;
    logic [7:0] data;
    logic rdy0, en0, wr0, be0, busy0, done0, err0;
    logic rdy1, en1, wr1, be1, busy1, done1, err1;
    logic [16:0] addr0;
    logic [9:0]  addr1;
    logic [31:0] wdata0, wdata1;
    logic rdy, en, wr, be, busy, done, err;
    logic [31:0] addr, wdata;
    int checks = 0, errors = 0;
    logic [31:0] wq_a[$], wq_d[$];

    always #5 clk = ~clk;

    ram_loader u0 (
        .clk(clk), .rst(rst), .start_i(start & ~sel), .in_valid_i(valid & ~sel), .in_data_i(data),
        .in_ready_o(rdy0), .ram_en_o(en0), .ram_wr_o(wr0), .ram_be_o(be0), .ram_addr_o(addr0),
        .ram_wdata_o(wdata0), .busy_o(busy0), .done_o(done0), .err_o(err0)
    );
    ram_loader #(.num_kbytes(1), .base_addr(32'h3F8)) u1 (
        .clk(clk), .rst(rst), .start_i(start & sel), .in_valid_i(valid & sel), .in_data_i(data),
        .in_ready_o(rdy1), .ram_en_o(en1), .ram_wr_o(wr1), .ram_be_o(be1), .ram_addr_o(addr1),
        .ram_wdata_o(wdata1), .busy_o(busy1), .done_o(done1), .err_o(err1)
    );

    assign rdy   = sel ? rdy1 : rdy0;
    assign en    = sel ? en1 : en0;
    assign wr    = sel ? wr1 : wr0;
    assign be    = sel ? be1 : be0;
    assign busy  = sel ? busy1 : busy0;
    assign done  = sel ? done1 : done0;
    assign err   = sel ? err1 : err0;
    assign addr  = sel ? 32'(addr1) : 32'(addr0);
    assign wdata = sel ? wdata1 : wdata0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (wr) begin
            wq_a.push_back(addr);
            wq_d.push_back(wdata);
            chk("wr_en_be", {en, be}, 2'b10);
        end else if (!rst) begin
            chk("idle_bus", {en, be, addr, wdata}, '0);
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        int g = gaps ? int'($urandom_range(0, 3)) : 0;
        repeat (g) begin valid = 1'b0; @(negedge clk); end
        valid = 1'b1;
        data  = b;
        while (!rdy && t < 20) begin @(negedge clk); t++; end
        if (t == 20) chk("ready_timeout", 1, 0);
        @(negedge clk) valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] n, input logic [127:0] p, input int np,
                        input logic [7:0] cs, input bit send_cs, input bit mid);
        wq_a.delete();
        wq_d.delete();
        pulse_start();
        chk("start_clr", {busy, done, err}, 3'b100);
        for (int i = 0; i < 4; i++) send(n[8*i +: 8]);
        for (int k = 0; k < np; k++) begin
            send(p[8*k +: 8]);
            if (mid && k == 2) pulse_start();
        end
        if (send_cs) send(cs);
    endtask

    task automatic chkw(input string tag, input int n, input logic [31:0] a0, input logic [31:0] d0,
                        input logic [31:0] a1, input logic [31:0] d1);
        chk({tag, "_nwr"}, wq_a.size(), n);
        if (n > 0) chk({tag, "_w0"}, {wq_a[0], wq_d[0]}, {a0, d0});
        if (n > 1) chk({tag, "_w1"}, {wq_a[1], wq_d[1]}, {a1, d1});
    endtask

    localparam logic [127:0] p1 = 128'h88776655_44332211;
    localparam logic [127:0] p2 = 128'h05_04030201;
    localparam logic [127:0] p3 = 128'h1807f6e5_d4c3b2a1;

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0; sel = 1'b0; gaps = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out", {busy, done, err, rdy, en, wr, be, addr, wdata}, '0);
        rst = 1'b0;
        @(negedge clk);
        load(8, p1, 8, 8'h88, 1, 0);
        chk("two_words_st", {busy, done, err}, 3'b010);
        chkw("two_words", 2, 0, 32'h44332211, 4, 32'h88776655);
        load(8, p1, 8, 8'h08, 1, 0);
        chk("bad_csum_st", {busy, done, err}, 3'b001);
        load(5, p2, 5, 8'h01, 1, 0);
        chk("partial_st", {busy, done, err}, 3'b010);
        chkw("partial", 2, 0, 32'h04030201, 4, 32'h00000005);
        load(0, 0, 0, 8'h00, 1, 0);
        chk("empty_st", {busy, done, err}, 3'b010);
        chkw("empty", 0, 0, 0, 0, 0);
        load(0, 0, 0, 8'h01, 1, 0);
        chk("empty_bad_st", {busy, done, err}, 3'b001);
        sel = 1'b1;
        load(12, 0, 0, 0, 0, 0);
        chk("over12_st", {busy, done, err, rdy}, 4'b0010);
        chkw("over12", 0, 0, 0, 0, 0);
        load(9, 0, 0, 0, 0, 0);
        chk("over9_st", {busy, done, err}, 3'b001);
        load(8, p3, 8, 8'h08, 1, 0);
        chk("fill_st", {busy, done, err}, 3'b010);
        chkw("fill", 2, 32'h3F8, 32'hd4c3b2a1, 32'h3FC, 32'h1807f6e5);
        sel = 1'b0;
        gaps = 1'b1;
        load(8, p1, 8, 8'h88, 1, 1);
        chk("gaps_st", {busy, done, err}, 3'b010);
        chkw("gaps", 2, 0, 32'h44332211, 4, 32'h88776655);
        gaps = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) send(i == 0 ? 8'd8 : 8'd0);
        for (int k = 0; k < 4; k++) send(p1[8*k +: 8]);
        chk("pre_rst_wr", {wr, busy}, 2'b11);
        rst = 1'b1;
        #1 chk("wr_in_rst", wr, 0);
        @(negedge clk);
        chk("rst_in_write", {busy, done, err, rdy, en, wr, be, addr, wdata}, '0);
        rst = 1'b0;
        load(5, p2, 5, 8'h01, 1, 0);
        chk("after_rst_st", {busy, done, err}, 3'b010);
        chkw("after_rst", 2, 0, 32'h04030201, 4, 32'h00000005);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
